// File: rtl/alu_pkg.sv
// -----------------------------------------------------------------------------
// alu_pkg -- shared constants for the alu_seq block.
//   ALU_WIDTH_DEF : default datapath width
//   OP_*          : 4-bit operation codes
//   ST_*          : FSM state encoding (IDLE / BUSY / DONE)
//   MD_*          : iterative-unit operating mode
//   is_muldiv()   : true for opcodes served by the iterative unit
//   muldiv_mode() : opcode -> iterative-unit mode
// -----------------------------------------------------------------------------
package alu_pkg;

  localparam int ALU_WIDTH_DEF = 32;

  localparam logic [3:0] OP_AND  = 4'd0;
  localparam logic [3:0] OP_OR   = 4'd1;
  localparam logic [3:0] OP_ADD  = 4'd2;
  localparam logic [3:0] OP_XOR  = 4'd3;
  localparam logic [3:0] OP_NOR  = 4'd4;
  localparam logic [3:0] OP_SLL  = 4'd5;
  localparam logic [3:0] OP_SUB  = 4'd6;
  localparam logic [3:0] OP_SLT  = 4'd7;
  localparam logic [3:0] OP_SLTU = 4'd8;
  localparam logic [3:0] OP_SRL  = 4'd9;
  localparam logic [3:0] OP_SRA  = 4'd10;
  localparam logic [3:0] OP_MUL  = 4'd11;
  localparam logic [3:0] OP_DIVU = 4'd12;
  localparam logic [3:0] OP_REMU = 4'd13;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_BUSY = 2'd1;
  localparam logic [1:0] ST_DONE = 2'd2;

  localparam logic [1:0] MD_MUL  = 2'd0;
  localparam logic [1:0] MD_DIVU = 2'd1;
  localparam logic [1:0] MD_REMU = 2'd2;

  function automatic logic is_muldiv(input logic [3:0] op);
    return (op == OP_MUL) || (op == OP_DIVU) || (op == OP_REMU);
  endfunction

  function automatic logic [1:0] muldiv_mode(input logic [3:0] op);
    case (op)
      OP_DIVU: return MD_DIVU;
      OP_REMU: return MD_REMU;
      default: return MD_MUL;
    endcase
  endfunction

endpackage

// File: rtl/alu_seq_muldiv.sv
// -----------------------------------------------------------------------------
// alu_seq_muldiv -- iterative shift-add multiplier / restoring divider,
// one bit per cycle, WIDTH iterations per operation.
//   clk, rst      : clock, asynchronous active-high reset
//   start         : load operands and begin (ignored while busy)
//   mode          : MD_MUL / MD_DIVU / MD_REMU
//   opa, opb      : multiplicand/dividend, multiplier/divisor
//   done          : high during the last iteration cycle
//   result        : final result, valid while done is high
// -----------------------------------------------------------------------------
module alu_seq_muldiv
  import alu_pkg::*;
#(
  parameter int WIDTH = ALU_WIDTH_DEF
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [1:0]       mode,
  input  logic [WIDTH-1:0] opa,
  input  logic [WIDTH-1:0] opb,
  output logic             done,
  output logic [WIDTH-1:0] result
);

  localparam int CW = $clog2(WIDTH) + 1;

  // a: product accumulator / partial remainder
  // b: shifting multiplicand / divisor
  // c: shifting multiplier / dividend that fills with quotient bits
  logic [WIDTH-1:0] a_q, a_d, b_q, b_d, c_q, c_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [1:0]       mode_q, mode_d;
  logic             busy_q, busy_d;

  logic [WIDTH:0]   r_shift, trial;
  logic             q_bit;

  assign done = busy_q && (cnt_q == CW'(WIDTH - 1));

  // A zero divisor never makes the trial subtraction negative, so the
  // quotient fills with ones and the dividend shifts through into the
  // remainder unchanged: divide-by-zero needs no special case.
  always_comb begin
    r_shift = {a_q, c_q[WIDTH-1]};
    trial   = r_shift - {1'b0, b_q};
    q_bit   = ~trial[WIDTH];
  end

  // NOTE: every always_comb output gets a default first so no path
  // leaves it unassigned and a latch is never inferred.
  always_comb begin
    a_d    = a_q;
    b_d    = b_q;
    c_d    = c_q;
    cnt_d  = cnt_q;
    mode_d = mode_q;
    busy_d = busy_q;
    if (busy_q) begin
      if (mode_q == MD_MUL) begin
        a_d = a_q + (c_q[0] ? b_q : '0);
        b_d = b_q << 1;
        c_d = c_q >> 1;
      end else begin
        a_d = q_bit ? trial[WIDTH-1:0] : r_shift[WIDTH-1:0];
        c_d = {c_q[WIDTH-2:0], q_bit};
      end
      cnt_d = cnt_q + 1'b1;
      if (done) busy_d = 1'b0;
    end else if (start) begin
      a_d    = '0;
      mode_d = mode;
      busy_d = 1'b1;
      cnt_d  = '0;
      if (mode == MD_MUL) begin
        b_d = opa;
        c_d = opb;
      end else begin
        b_d = opb;
        c_d = opa;
      end
    end
  end

  // The final iteration's next-state values are the answer, so the
  // parent can register the result on the same edge the unit finishes.
  always_comb begin
    case (mode_q)
      MD_DIVU: result = c_d;
      default: result = a_d;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every flop
  // samples the pre-edge values regardless of statement order.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      a_q    <= '0;
      b_q    <= '0;
      c_q    <= '0;
      cnt_q  <= '0;
      mode_q <= MD_MUL;
      busy_q <= 1'b0;
    end else begin
      a_q    <= a_d;
      b_q    <= b_d;
      c_q    <= c_d;
      cnt_q  <= cnt_d;
      mode_q <= mode_d;
      busy_q <= busy_d;
    end
  end

endmodule

// File: rtl/alu_seq.sv
// -----------------------------------------------------------------------------
// alu_seq -- sequential ALU with valid/ready request and result handshakes.
// Single-cycle ops complete IDLE -> DONE; MUL/DIVU/REMU run IDLE -> BUSY
// (WIDTH cycles) -> DONE through alu_seq_muldiv. The result is held in DONE
// until out_ready.
// Build option: define ALU_SEQ_MULDIV_EN to include the iterative unit;
// otherwise opcodes 11-13 are reported as illegal.
//   clk, rst            : clock, asynchronous active-high reset
//   in_valid, in_ready  : request handshake (in_ready only in IDLE)
//   aluop, in1, in2     : operation and operands, captured on acceptance
//   out_valid, out_ready: result handshake
//   out, zero, ovf      : registered result and flags
//   illegal             : unsupported opcode reported with the result
// -----------------------------------------------------------------------------
module alu_seq
  import alu_pkg::*;
#(
  parameter int WIDTH = ALU_WIDTH_DEF,
  parameter int OPW   = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [OPW-1:0]   aluop,
  input  logic [WIDTH-1:0] in1,
  input  logic [WIDTH-1:0] in2,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out,
  output logic             zero,
  output logic             ovf,
  output logic             illegal
);

  localparam int SHW = $clog2(WIDTH);

  logic [1:0]       state_q, state_d;
  logic [WIDTH-1:0] out_q, out_d;
  logic             zero_q, zero_d, ovf_q, ovf_d, ill_q, ill_d;

  logic [WIDTH-1:0] alu_res, sum, diff;
  logic             alu_ovf, alu_ill;
  logic [SHW-1:0]   shamt;
  logic             accept;

  assign in_ready  = (state_q == ST_IDLE);
  assign out_valid = (state_q == ST_DONE);
  assign accept    = in_valid && in_ready;
  assign out       = out_q;
  assign zero      = zero_q;
  assign ovf       = ovf_q;
  assign illegal   = ill_q;

`ifdef ALU_SEQ_MULDIV_EN
  logic             md_start, md_done;
  logic [WIDTH-1:0] md_result;

  assign md_start = accept && is_muldiv(aluop);

  alu_seq_muldiv #(.WIDTH(WIDTH)) u_muldiv (
    .clk    (clk),
    .rst    (rst),
    .start  (md_start),
    .mode   (muldiv_mode(aluop)),
    .opa    (in1),
    .opb    (in2),
    .done   (md_done),
    .result (md_result)
  );
`endif

  // Single-cycle datapath, evaluated on the request operands.
  always_comb begin
    sum     = in1 + in2;
    diff    = in1 - in2;
    shamt   = in2[SHW-1:0];
    alu_res = '0;
    alu_ovf = 1'b0;
    alu_ill = 1'b0;
    case (aluop)
      OP_AND:  alu_res = in1 & in2;
      OP_OR:   alu_res = in1 | in2;
      OP_XOR:  alu_res = in1 ^ in2;
      OP_NOR:  alu_res = ~(in1 | in2);
      OP_SLL:  alu_res = in1 << shamt;
      OP_SRL:  alu_res = in1 >> shamt;
      OP_SRA:  alu_res = $signed(in1) >>> shamt;
      OP_SLT:  alu_res = {{(WIDTH-1){1'b0}}, ($signed(in1) < $signed(in2))};
      OP_SLTU: alu_res = {{(WIDTH-1){1'b0}}, (in1 < in2)};
      OP_ADD: begin
        alu_res = sum;
        // Same-sign operands producing a result of the other sign.
        alu_ovf = (in1[WIDTH-1] == in2[WIDTH-1]) && (sum[WIDTH-1] != in1[WIDTH-1]);
      end
      OP_SUB: begin
        alu_res = diff;
        alu_ovf = (in1[WIDTH-1] != in2[WIDTH-1]) && (diff[WIDTH-1] != in1[WIDTH-1]);
      end
      default: alu_ill = 1'b1;
    endcase
  end

  always_comb begin
    state_d = state_q;
    out_d   = out_q;
    zero_d  = zero_q;
    ovf_d   = ovf_q;
    ill_d   = ill_q;
    case (state_q)
      ST_IDLE: begin
        if (accept) begin
`ifdef ALU_SEQ_MULDIV_EN
          if (is_muldiv(aluop)) begin
            state_d = ST_BUSY;
          end else
`endif
          begin
            state_d = ST_DONE;
            out_d   = alu_res;
            zero_d  = (alu_res == '0);
            ovf_d   = alu_ovf;
            ill_d   = alu_ill;
          end
        end
      end
`ifdef ALU_SEQ_MULDIV_EN
      ST_BUSY: begin
        if (md_done) begin
          state_d = ST_DONE;
          out_d   = md_result;
          zero_d  = (md_result == '0);
          ovf_d   = 1'b0;
          ill_d   = 1'b0;
        end
      end
`endif
      ST_DONE: begin
        if (out_ready) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_IDLE;
      out_q   <= '0;
      zero_q  <= 1'b0;
      ovf_q   <= 1'b0;
      ill_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      out_q   <= out_d;
      zero_q  <= zero_d;
      ovf_q   <= ovf_d;
      ill_q   <= ill_d;
    end
  end

endmodule

// File: tb/tb_alu_seq.sv
// -----------------------------------------------------------------------------
// tb_alu_seq -- directed self-checking bench for alu_seq (WIDTH = 32).
// Expected results are hand-computed constants. Opcodes 11-13 are checked
// as arithmetic when ALU_SEQ_MULDIV_EN is defined, otherwise as illegal.
// -----------------------------------------------------------------------------
module tb_alu_seq;
  import alu_pkg::*;

  localparam int W = 32;

  logic         clk = 1'b0;
  logic         rst;
  logic         in_valid;
  logic         in_ready;
  logic [3:0]   aluop;
  logic [W-1:0] in1, in2;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] out;
  logic         zero, ovf, illegal;

  int n_checks = 0;
  int n_pass   = 0;

  always #5 clk = ~clk;

  alu_seq #(.WIDTH(W), .OPW(4)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .aluop     (aluop),
    .in1       (in1),
    .in2       (in2),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out       (out),
    .zero      (zero),
    .ovf       (ovf),
    .illegal   (illegal)
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  // Issue one request, wait for the result, optionally hold it in DONE
  // for 'hold' cycles with distracting requests, then release it.
  task automatic do_op(input string name, input logic [3:0] op,
                       input logic [W-1:0] a, input logic [W-1:0] b,
                       input logic [W-1:0] e_out, input logic e_z,
                       input logic e_ovf, input logic e_ill,
                       input int e_lat, input int hold);
    int lat = 0;
    bit got_valid = 0;
    bit rdy_seen = 0;
    @(negedge clk);
    check({name, ".rdy"}, in_ready, 1);
    in_valid = 1'b1; aluop = op; in1 = a; in2 = b;
    @(posedge clk);
    #1;
    // Scramble inputs after acceptance: the result must not depend on them.
    in_valid = 1'b0; aluop = OP_AND; in1 = ~a; in2 = ~b;
    while (lat < 200) begin
      @(negedge clk);
      lat++;
      if (out_valid) begin
        got_valid = 1;
        break;
      end
      if (in_ready) rdy_seen = 1;
    end
    check({name, ".lat"}, lat, e_lat);
    if (!got_valid) return;
    check({name, ".out"}, out, e_out);
    check({name, ".flags"}, {zero, ovf, illegal}, {e_z, e_ovf, e_ill});
    check({name, ".busy_rdy"}, {rdy_seen, in_ready}, 2'b00);
    if (hold > 0) begin
      in_valid = 1'b1; aluop = OP_ADD; in1 = 1; in2 = 1;
      repeat (hold) @(negedge clk);
      check({name, ".hold_out"}, out, e_out);
      check({name, ".hold_hs"}, {out_valid, in_ready, zero, ovf, illegal},
            {1'b1, 1'b0, e_z, e_ovf, e_ill});
      in_valid = 1'b0;
    end
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    check({name, ".idle"}, {in_ready, out_valid}, 2'b10);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
    aluop = '0; in1 = '0; in2 = '0;
    repeat (3) @(negedge clk);
    check("rst.out", out, 0);
    check("rst.flags", {out_valid, zero, ovf, illegal}, 4'b0000);
    rst = 1'b0;
    #1;
    check("rst.rdy", in_ready, 1);

    //     name      op       in1            in2            out            z  ov il lat hold
    do_op("add_ovf", OP_ADD,  32'h7FFFFFFF,  32'h1,         32'h80000000,  0, 1, 0, 1, 0);
    do_op("add_wrap",OP_ADD,  32'hFFFFFFFF,  32'h1,         32'h0,         1, 0, 0, 1, 0);
    do_op("sub_zero",OP_SUB,  32'd5,         32'd5,         32'h0,         1, 0, 0, 1, 0);
    do_op("sub_ovf", OP_SUB,  32'h80000000,  32'h1,         32'h7FFFFFFF,  0, 1, 0, 1, 0);
    do_op("slt",     OP_SLT,  32'hFFFFFFFF,  32'h1,         32'h1,         0, 0, 0, 1, 0);
    do_op("sltu",    OP_SLTU, 32'hFFFFFFFF,  32'h1,         32'h0,         1, 0, 0, 1, 0);
    do_op("and",     OP_AND,  32'hF0F0F0F0,  32'hFF00FF00,  32'hF000F000,  0, 0, 0, 1, 0);
    do_op("or",      OP_OR,   32'h0F0F0000,  32'h0000FF00,  32'h0F0FFF00,  0, 0, 0, 1, 0);
    do_op("xor",     OP_XOR,  32'hA5A5A5A5,  32'hFFFFFFFF,  32'h5A5A5A5A,  0, 0, 0, 1, 0);
    do_op("nor",     OP_NOR,  32'h0,         32'h0,         32'hFFFFFFFF,  0, 0, 0, 1, 0);
    do_op("sll",     OP_SLL,  32'h1,         32'd35,        32'h8,         0, 0, 0, 1, 0);
    do_op("srl",     OP_SRL,  32'h80000000,  32'd4,         32'h08000000,  0, 0, 0, 1, 0);
    do_op("sra",     OP_SRA,  32'h80000000,  32'd4,         32'hF8000000,  0, 0, 0, 1, 0);
    do_op("hold",    OP_ADD,  32'd20,        32'd22,        32'd42,        0, 0, 0, 1, 5);
    do_op("ill14",   4'd14,   32'h1234,      32'h5678,      32'h0,         1, 0, 1, 1, 0);
    do_op("ill15",   4'd15,   32'hFFFFFFFF,  32'hFFFFFFFF,  32'h0,         1, 0, 1, 1, 0);

`ifdef ALU_SEQ_MULDIV_EN
    do_op("mul",     OP_MUL,  32'h0000FFFF,  32'h00010001,  32'hFFFFFFFF,  0, 0, 0, W+1, 0);
    do_op("divu",    OP_DIVU, 32'd100,       32'd7,         32'd14,        0, 0, 0, W+1, 0);
    do_op("remu",    OP_REMU, 32'd100,       32'd7,         32'd2,         0, 0, 0, W+1, 0);
    do_op("divu0",   OP_DIVU, 32'd9,         32'd0,         32'hFFFFFFFF,  0, 0, 0, W+1, 0);
    do_op("remu0",   OP_REMU, 32'd9,         32'd0,         32'd9,         0, 0, 0, W+1, 3);
    do_op("mul_z",   OP_MUL,  32'h00010000,  32'h00010000,  32'h0,         1, 0, 0, W+1, 0);

    // Reset during BUSY cycle 10: the result must never be presented.
    begin
      bit seen = 0;
      @(negedge clk);
      in_valid = 1'b1; aluop = OP_MUL; in1 = 32'd3; in2 = 32'd5;
      @(posedge clk);
      #1 in_valid = 1'b0;
      repeat (10) @(negedge clk);
      check("abort.busy", in_ready, 0);
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      #1;
      check("abort.rdy", in_ready, 1);
      check("abort.out", out, 0);
      repeat (2 * W) begin
        @(negedge clk);
        if (out_valid) seen = 1;
      end
      check("abort.novalid", seen, 0);
    end
`else
    do_op("ill_mul", OP_MUL,  32'h0000FFFF,  32'h00010001,  32'h0,         1, 0, 1, 1, 0);
    do_op("ill_divu",OP_DIVU, 32'd100,       32'd7,         32'h0,         1, 0, 1, 1, 0);
    do_op("ill_remu",OP_REMU, 32'd9,         32'd0,         32'h0,         1, 0, 1, 1, 0);
`endif

    do_op("post",    OP_ADD,  32'd1,         32'd2,         32'd3,         0, 0, 0, 1, 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/alu_seq.md
ALU_SEQ -- requirements
Module: alu_seq

Interface
REQ-001 SHALL have parameter WIDTH, default 32, datapath width in bits; legal range 8..64.
REQ-002 SHALL have parameter OPW, default 4, opcode width in bits; fixed at 4.
REQ-003 SHALL have port clk  input  1  single clock; all state on rising edge.
REQ-004 SHALL have port rst  input  1  asynchronous, active-high reset.
REQ-005 SHALL have port in_valid  input  1  operation request.
REQ-006 SHALL have port in_ready  output  1  block accepts a request this cycle.
REQ-007 SHALL have port aluop  input  OPW  operation code.
REQ-008 SHALL have port in1, in2  input  WIDTH  operands.
REQ-009 SHALL have port out_valid  output  1  result available.
REQ-010 SHALL have port out_ready  input  1  consumer takes result.
REQ-011 SHALL have port out  output  WIDTH  registered result.
REQ-012 SHALL have port zero  output  1  high when out == 0, all ops.
REQ-013 SHALL have port ovf  output  1  signed overflow for ADD/SUB, else 0.
REQ-014 SHALL have port illegal  output  1  unsupported opcode reported with result.

Function
REQ-015 SHALL implement FSM IDLE, BUSY, DONE; in_ready = (state == IDLE).
REQ-016 SHALL accept a request on in_valid && in_ready, capturing aluop, in1, in2.
REQ-017 SHALL support opcodes: 0 AND, 1 OR, 2 ADD, 3 XOR, 4 NOR, 5 SLL, 6 SUB, 7 SLT (signed), 8 SLTU, 9 SRL, 10 SRA, 11 MUL (low WIDTH bits), 12 DIVU, 13 REMU.
REQ-018 SHALL complete single-cycle ops IDLE -> DONE: out_valid high the cycle after acceptance.
REQ-019 SHALL execute MUL, DIVU, REMU iteratively, one bit per cycle: IDLE -> BUSY for WIDTH cycles -> DONE; out_valid high WIDTH+1 cycles after acceptance.
REQ-020 SHALL use shift amount in2[$clog2(WIDTH)-1:0] for SLL/SRL/SRA.
REQ-021 SHALL return, for divide by zero, DIVU = all ones and REMU = in1, with no extra latency.
REQ-022 SHALL compute zero and ovf from the final result and register them with out.
REQ-023 SHALL hold out, zero, ovf, illegal and out_valid stable in DONE until out_ready; DONE -> IDLE on out_valid && out_ready.
REQ-024 SHALL not accept a new request in the cycle DONE is left (no same-cycle turnaround).
REQ-025 SHALL, for an unsupported opcode, complete in one cycle with out = 0, zero = 1, illegal = 1.
REQ-026 SHALL ignore in_valid, aluop and operand changes while BUSY or DONE.

Reset
REQ-027 SHALL on rst force state IDLE, out = 0, zero = 0, ovf = 0, illegal = 0, out_valid = 0, iteration counter and working registers = 0.
REQ-028 SHALL abandon an operation in progress on reset mid-BUSY with no result ever presented.
REQ-029 SHALL drive in_ready = 1 in the first cycle after rst deasserts.

Configuration
REQ-030 SHALL compile iterative unit only when macro ALU_SEQ_MULDIV_EN is defined.
REQ-031 SHALL, without ALU_SEQ_MULDIV_EN, treat opcodes 11-13 as unsupported per REQ-025 and contain no BUSY-path logic.

Structure
REQ-032 SHALL place opcode constants, FSM state encoding and WIDTH default in shared package alu_pkg.
REQ-033 SHALL implement shift-add multiply and restoring divide in one sub-module alu_seq_muldiv (start/done handshake, WIDTH iterations).

Verification
REQ-034 SHALL cover ADD 32'h7FFFFFFF + 1 -> out 32'h80000000, ovf 1, zero 0, out_valid one cycle after accept.
REQ-035 SHALL cover SUB 5 - 5 -> out 0, zero 1; SLT -1,1 -> 1; SLTU -1,1 -> 0.
REQ-036 SHALL cover MUL 32'hFFFF x 32'h10001 -> 32'hFFFFFFFF, out_valid exactly 33 cycles after accept, in_ready low throughout.
REQ-037 SHALL cover DIVU 100/7 -> 14, REMU 100/7 -> 2, DIVU 9/0 -> 32'hFFFFFFFF, REMU 9/0 -> 9.
REQ-038 SHALL cover out_ready held low 5 cycles in DONE -> out stable, no new accept; rst asserted at BUSY cycle 10 -> out_valid never rises, in_ready 1 after release.
REQ-039 SHALL cover opcode 15 (and 11 without ALU_SEQ_MULDIV_EN) -> illegal 1, out 0, zero 1, one-cycle latency.
